// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Contents:
//   - loader state encoding (IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR)
//   - err_code values reported on the err_code output
//   - default frame start byte
//   - checksum and state-classification helper functions
package imem_boot_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LEN0  = 3'd1;
  localparam state_t ST_LEN1  = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_CSUM  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;
  localparam state_t ST_ERROR = 3'd6;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // Running frame checksum: plain XOR of the payload bytes.
  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

  // States that sit inside a frame and are subject to the byte timeout.
  function automatic logic frame_active(input state_t st);
    logic act;
    case (st)
      ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: act = 1'b1;
      default:                            act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Bus bundle between the boot loader, its byte source and the instruction memory.
// Signals:
//   rx_valid/rx_data/rx_ready : byte stream handshake (source -> loader)
//   skip_load/load_req        : host control requests
//   imem_we/imem_waddr/wdata  : instruction memory write port
//   core_hold/done/err_code   : status towards the core and the host
// Modports: slave = the loader, master = the environment driving it.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              skip_load;
  logic              load_req;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic [1:0]        err_code;

  modport slave (
    input  rx_valid, rx_data, skip_load, load_req,
    output rx_ready, imem_we, imem_waddr, imem_wdata, core_hold, done, err_code
  );

  modport master (
    output rx_valid, rx_data, skip_load, load_req,
    input  rx_ready, imem_we, imem_waddr, imem_wdata, core_hold, done, err_code
  );
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Payload word assembler for the boot loader.
// Shifts accepted payload bytes into a little-endian 32-bit word, counts byte
// lanes and keeps the running XOR checksum of all payload bytes.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : start of a new frame, zero lane counter and checksum
//   accept      : byte_in is a payload byte this cycle
//   byte_in     : payload byte
//   word_valid  : byte_in completes a word (4th lane) this cycle
//   word        : completed word, valid with word_valid
//   csum        : XOR of all payload bytes accepted so far
module boot_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  // Only three bytes need holding: the fourth is taken straight from byte_in.
  logic [23:0] shift_r;
  logic [1:0]  lane_r;
  logic [7:0]  csum_r;

  // Word completion and assembled word for the current byte.
  always_comb begin
    word_valid = accept && (lane_r == 2'd3);
    word       = {byte_in, shift_r};
  end

  assign csum = csum_r;

  // Byte shift register, lane counter and running checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= 24'd0;
      lane_r  <= 2'd0;
      csum_r  <= 8'd0;
    end else if (clear) begin
      shift_r <= 24'd0;
      lane_r  <= 2'd0;
      csum_r  <= 8'd0;
    end else if (accept) begin
      shift_r <= {byte_in, shift_r[23:8]};
      lane_r  <= lane_r + 2'd1;
      csum_r  <= csum_update(csum_r, byte_in);
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader.
// Receives a framed byte stream (MAGIC, N low, N high, 4*N payload bytes,
// XOR checksum), writes the payload as little-endian words to the instruction
// memory and holds the core until a frame loads cleanly or loading is skipped.
// Ports:
//   clk    : system clock
//   reset  : synchronous active-high reset
//   bus    : imem_boot_loader_if.slave (byte handshake, host control,
//            memory write port, core_hold/done/err_code status)
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  imem_boot_loader_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);

  state_t            state_r, state_s;
  logic [1:0]        err_r, err_s;
  logic [15:0]       len_r, len_s;
  logic [ADDR_W-1:0] widx_r;
  logic [TMR_W-1:0]  timer_r;
  logic              rx_ready_r;
  logic              core_hold_r;
  logic              done_r;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [31:0]       wdata_r;

  logic              rx_ready_s;
  logic              accept_s;
  logic [15:0]       n_s;
  logic              len_ok_s;
  logic              last_word_s;
  logic              active_s;
  logic              tmo_s;
  logic              asm_clear_s;
  logic              asm_accept_s;
  logic              word_valid_s;
  logic [31:0]       word_s;
  logic [7:0]        csum_s;

  // Handshake and frame-condition decode. A skip request in IDLE takes
  // priority over a byte, so the byte is refused in that same cycle.
  always_comb begin
    rx_ready_s   = rx_ready_r && !((state_r == ST_IDLE) && bus.skip_load);
    accept_s     = bus.rx_valid && rx_ready_s;
    n_s          = {bus.rx_data, len_r[7:0]};
    len_ok_s     = (n_s != 16'd0) && (32'(n_s) <= DEPTH);
    last_word_s  = (32'(widx_r) == (32'(len_r) - 32'd1));
    active_s     = frame_active(state_r);
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a byte.
    tmo_s        = active_s && !accept_s && (timer_r >= TMR_LAST);
    asm_clear_s  = (state_r == ST_IDLE) && accept_s && (bus.rx_data == MAGIC);
    asm_accept_s = accept_s && (state_r == ST_DATA);
  end

  boot_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear_s),
    .accept     (asm_accept_s),
    .byte_in    (bus.rx_data),
    .word_valid (word_valid_s),
    .word       (word_s),
    .csum       (csum_s)
  );

  // Next-state, error code and frame length.
  always_comb begin
    state_s = state_r;
    err_s   = err_r;
    len_s   = len_r;
    case (state_r)
      ST_IDLE: begin
        err_s = ERR_NONE;
        if (bus.skip_load) begin
          state_s = ST_DONE;
        end else if (accept_s && (bus.rx_data == MAGIC)) begin
          state_s = ST_LEN0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LEN0: begin
        if (accept_s) begin
          len_s   = {8'd0, bus.rx_data};
          state_s = ST_LEN1;
        end else if (tmo_s) begin
          state_s = ST_ERROR;
          err_s   = ERR_TIMEOUT;
        end else begin
          state_s = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (accept_s) begin
          len_s = n_s;
          if (len_ok_s) begin
            state_s = ST_DATA;
          end else begin
            state_s = ST_ERROR;
            err_s   = ERR_LEN;
          end
        end else if (tmo_s) begin
          state_s = ST_ERROR;
          err_s   = ERR_TIMEOUT;
        end else begin
          state_s = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (word_valid_s && last_word_s) begin
          state_s = ST_CSUM;
        end else if (tmo_s) begin
          state_s = ST_ERROR;
          err_s   = ERR_TIMEOUT;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          if (bus.rx_data == csum_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ERROR;
            err_s   = ERR_CSUM;
          end
        end else if (tmo_s) begin
          state_s = ST_ERROR;
          err_s   = ERR_TIMEOUT;
        end else begin
          state_s = ST_CSUM;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (bus.load_req) begin
          state_s = ST_IDLE;
          err_s   = ERR_NONE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        err_s   = ERR_NONE;
      end
    endcase
  end

  // FSM state and status outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      err_r       <= ERR_NONE;
      len_r       <= 16'd0;
      rx_ready_r  <= 1'b0;
      core_hold_r <= 1'b1;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      err_r       <= err_s;
      len_r       <= len_s;
      rx_ready_r  <= frame_active(state_s) || (state_s == ST_IDLE);
      core_hold_r <= (state_s != ST_DONE);
      done_r      <= (state_s == ST_DONE);
    end
  end

  // Memory write strobe one cycle after a word completes; word index
  // restarts at zero for every frame and is never used past N-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r    <= 1'b0;
      waddr_r <= {ADDR_W{1'b0}};
      wdata_r <= 32'd0;
      widx_r  <= {ADDR_W{1'b0}};
    end else begin
      we_r <= word_valid_s;
      if (word_valid_s) begin
        waddr_r <= widx_r;
        wdata_r <= word_s;
        widx_r  <= widx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else if (state_r == ST_LEN1) begin
        widx_r <= {ADDR_W{1'b0}};
      end
    end
  end

  // Inter-byte idle counter, saturating, cleared on any accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= {TMR_W{1'b0}};
    end else if (accept_s || !active_s) begin
      timer_r <= {TMR_W{1'b0}};
    end else if (timer_r != TMR_MAX) begin
      timer_r <= timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.rx_ready   = rx_ready_s;
  assign bus.imem_we    = we_r;
  assign bus.imem_waddr = waddr_r;
  assign bus.imem_wdata = wdata_r;
  assign bus.core_hold  = core_hold_r;
  assign bus.done       = done_r;
  assign bus.err_code   = err_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frame-level reference model,
// per-cycle output compare, directed scenarios and randomized frames.
module tb_imem_boot_loader;

  localparam int unsigned AW  = 8;
  localparam int          TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(AW)) bus ();

  imem_boot_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO), .MAGIC(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- reference model (frame-position based) ----------------
  localparam int M_IDLE = 0, M_FRAME = 1, M_DONE = 2, M_ERR = 3;
  int          m_mode = M_IDLE;
  bit          m_rst_cycle = 1'b1;
  bit          m_started = 1'b0;
  int          m_pos, m_n, m_gap;
  logic [7:0]  m_lo, m_x;
  logic [7:0]  m_pl[$];
  logic        e_we = 1'b0;
  logic [AW-1:0] e_waddr = '0;
  logic [31:0] e_wdata = 32'd0;
  logic [1:0]  e_err = 2'd0;

  always @(posedge clk) begin : model
    logic [7:0] b;
    int p;
    m_started = 1'b1;
    e_we = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_rst_cycle = 1'b1;
      e_waddr = '0; e_wdata = 32'd0; e_err = 2'd0; m_gap = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (bus.skip_load) m_mode = M_DONE;
          else if (bus.rx_valid && !m_rst_cycle && bus.rx_data == 8'hA5) begin
            m_mode = M_FRAME; m_pos = 0; m_x = 8'd0; m_gap = 0; m_pl.delete();
          end
        end
        M_FRAME: begin
          if (bus.rx_valid) begin
            b = bus.rx_data; m_gap = 0; m_pos++;
            if (m_pos == 1) m_lo = b;
            else if (m_pos == 2) begin
              m_n = int'(b) * 256 + int'(m_lo);
              if (m_n < 1 || m_n > 256) begin m_mode = M_ERR; e_err = 2'd1; end
            end else begin
              p = m_pos - 3;
              if (p < 4 * m_n) begin
                m_pl.push_back(b); m_x ^= b;
                if (p % 4 == 3) begin
                  e_we = 1'b1; e_waddr = AW'(p / 4);
                  e_wdata = {m_pl[p], m_pl[p-1], m_pl[p-2], m_pl[p-3]};
                end
              end else if (b == m_x) m_mode = M_DONE;
              else begin m_mode = M_ERR; e_err = 2'd2; end
            end
          end else begin
            m_gap++;
            if (m_gap >= TMO) begin m_mode = M_ERR; e_err = 2'd3; end
          end
        end
        default: if (bus.load_req) begin m_mode = M_IDLE; e_err = 2'd0; end
      endcase
      m_rst_cycle = 1'b0;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (m_started) begin
      check("rx_ready", bus.rx_ready,
            !m_rst_cycle && ((m_mode == M_IDLE && !bus.skip_load) || m_mode == M_FRAME));
      check("imem_we", bus.imem_we, e_we);
      check("imem_waddr", bus.imem_waddr, e_waddr);
      check("imem_wdata", bus.imem_wdata, e_wdata);
      check("core_hold", bus.core_hold, m_mode != M_DONE);
      check("done", bus.done, m_mode == M_DONE);
      check("err_code", bus.err_code, e_err);
    end
  end

  // Write log for the directed literal checks.
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wa.push_back(bus.imem_waddr);
      wd.push_back(bus.imem_wdata);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] nom[12] = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00,
                          8'h13, 8'h01, 8'h50, 8'h00, 8'hD1};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int bound;
    logic acc;
    bus.rx_valid = 1'b0;
    repeat (gap) tick();
    bus.rx_valid = 1'b1; bus.rx_data = b;
    bound = 0;
    forever begin
      #1; acc = bus.rx_ready;
      tick();
      if (acc) break;
      bound++;
      if (bound > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL send_bound: byte %0h not accepted within 40 cycles", b);
        break;
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_nom(input int count, input int gap, input logic [7:0] last);
    for (int i = 0; i < count; i++) send((i == 11) ? last : nom[i], gap);
  endtask

  task automatic load_req();
    bus.load_req = 1'b1; tick(); bus.load_req = 1'b0;
  endtask

  task automatic frame(input int n, input bit bad, input int maxgap);
    logic [15:0] n16;
    logic [7:0] x, b;
    n16 = 16'(n); x = 8'd0;
    send(8'hA5, $urandom_range(0, maxgap));
    send(n16[7:0], $urandom_range(0, maxgap));
    send(n16[15:8], $urandom_range(0, maxgap));
    if (n >= 1 && n <= 256) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom); x ^= b;
        send(b, $urandom_range(0, maxgap));
      end
      send(bad ? (x ^ 8'(1 << $urandom_range(0, 7))) : x, $urandom_range(0, maxgap));
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int base;
    bus.rx_valid = 1'b0; bus.rx_data = 8'd0; bus.skip_load = 1'b0; bus.load_req = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    check("rst_core_hold", bus.core_hold, 1);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_we", bus.imem_we, 0);
    reset = 1'b0;
    tick();
    check("idle_rx_ready", bus.rx_ready, 1);

    // Nominal load
    base = wa.size();
    send_nom(12, 0, 8'hD1);
    check("nom_nwrites", wa.size() - base, 2);
    check("nom_a0", wa[base], 0);
    check("nom_d0", wd[base], 32'h0000_0093);
    check("nom_a1", wa[base+1], 1);
    check("nom_d1", wd[base+1], 32'h0050_0113);
    check("nom_done", bus.done, 1);
    check("nom_hold", bus.core_hold, 0);
    check("nom_err", bus.err_code, 0);
    check("nom_ready", bus.rx_ready, 0);
    load_req();

    // Bad checksum
    base = wa.size();
    send_nom(12, 0, 8'hD0);
    check("csum_nwrites", wa.size() - base, 2);
    check("csum_err", bus.err_code, 2);
    check("csum_hold", bus.core_hold, 1);
    check("csum_done", bus.done, 0);
    load_req();
    check("csum_rearm_ready", bus.rx_ready, 1);
    check("csum_rearm_err", bus.err_code, 0);

    // Bad lengths
    base = wa.size();
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
    check("len0_err", bus.err_code, 1);
    load_req();
    send(8'hA5, 0); send(8'h01, 0); send(8'h01, 0);
    check("len257_err", bus.err_code, 1);
    check("len_nwrites", wa.size() - base, 0);
    load_req();

    // Gapped frame completes
    send_nom(12, 10, 8'hD1);
    check("gap_done", bus.done, 1);
    load_req();

    // Stall after second payload byte
    base = wa.size();
    send_nom(5, 0, 8'hD1);
    bus.rx_valid = 1'b0;
    repeat (20) tick();
    check("tmo_err", bus.err_code, 3);
    check("tmo_nwrites", wa.size() - base, 0);
    load_req();

    // Noise then skip
    base = wa.size();
    send(8'h00, 0); send(8'hFF, 0); send(8'h13, 0);
    check("noise_hold", bus.core_hold, 1);
    check("noise_ready", bus.rx_ready, 1);
    bus.skip_load = 1'b1; tick(); bus.skip_load = 1'b0;
    check("skip_done", bus.done, 1);
    check("skip_hold", bus.core_hold, 0);
    check("skip_ready", bus.rx_ready, 0);
    check("skip_nwrites", wa.size() - base, 0);
    load_req();

    // Skip and MAGIC in the same cycle: skip wins
    bus.rx_valid = 1'b1; bus.rx_data = 8'hA5; bus.skip_load = 1'b1;
    #1 check("skipbyte_ready", bus.rx_ready, 0);
    tick();
    bus.rx_valid = 1'b0; bus.skip_load = 1'b0;
    check("skipbyte_done", bus.done, 1);
    load_req();

    // Reset mid-frame
    send_nom(10, 0, 8'hD1);
    base = wa.size();
    reset = 1'b1; tick();
    check("mid_rst_hold", bus.core_hold, 1);
    check("mid_rst_we", bus.imem_we, 0);
    check("mid_rst_waddr", bus.imem_waddr, 0);
    check("mid_rst_wdata", bus.imem_wdata, 0);
    check("mid_rst_ready", bus.rx_ready, 0);
    reset = 1'b0; tick();
    send_nom(12, 0, 8'hD1);
    check("post_rst_nwrites", wa.size() - base, 2);
    check("post_rst_a0", wa[base], 0);
    check("post_rst_d1", wd[base+1], 32'h0050_0113);
    check("post_rst_done", bus.done, 1);
    load_req();

    // Full-depth frame
    base = wa.size();
    frame(256, 1'b0, 0);
    check("full_nwrites", wa.size() - base, 256);
    check("full_first", wa[base], 0);
    check("full_last", wa[base+255], 255);
    check("full_done", bus.done, 1);
    load_req();

    // Randomized traffic, checked by the model
    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) frame($urandom_range(1, 6), ($urandom_range(0, 3) == 0), $urandom_range(0, 12));
      else if (sel == 6) frame(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(257, 400), 1'b0, 2);
      else if (sel == 7) begin
        for (int k = 0; k < 3; k++) send(8'($urandom_range(0, 164)), $urandom_range(0, 3));
      end else if (sel == 8) begin
        bus.skip_load = 1'b1; tick(); bus.skip_load = 1'b0;
      end else begin
        send(8'hA5, 0); send(8'h01, 0);
        bus.rx_valid = 1'b0; repeat (TMO + 2) tick();
      end
      repeat ($urandom_range(0, 3)) tick();
      load_req();
    end

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
